// File: rtl/instruction_fetch_unit.sv
// Fetch front-end: owns the PC, issues one-cycle-latency reads to instruction memory
// and buffers returned words in a prefetch queue drained by decode via valid/ready.
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    INSTR_WIDTH = 16,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}}
) (
    input  logic                             clock,
    input  logic                             reset,
    output logic                             imem_req,
    output logic [ADDR_WIDTH-1:0]            imem_addr,
    input  logic [INSTR_WIDTH-1:0]           imem_rdata,
    input  logic                             redirect_valid,
    input  logic [ADDR_WIDTH-1:0]            redirect_pc,
    output logic                             instr_valid,
    output logic [INSTR_WIDTH-1:0]           instr,
    output logic [ADDR_WIDTH-1:0]            instr_pc,
    input  logic                             instr_ready,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [ADDR_WIDTH-1:0]  fetch_pc_r;
    logic                   inflight_r;
    logic [ADDR_WIDTH-1:0]  inflight_pc_r;
    logic [INSTR_WIDTH-1:0] data_mem_r [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem_r   [QUEUE_DEPTH];
    logic [PTR_W-1:0]       head_r;
    logic [PTR_W-1:0]       tail_r;
    logic [CNT_W-1:0]       count_r;

    logic                   valid_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   issue_s;
    logic [CNT_W:0]         demand_s;

    // Issue decision: queued + in-flight - leaving this cycle must leave a free slot.
    always_comb begin
        valid_s  = (count_r != {CNT_W{1'b0}});
        pop_s    = valid_s && instr_ready;
        demand_s = (CNT_W+1)'(count_r) + (CNT_W+1)'(inflight_r) - (CNT_W+1)'(pop_s);
        issue_s  = !reset && !redirect_valid && (demand_s < (CNT_W+1)'(QUEUE_DEPTH));
        // A redirect squashes the response landing this cycle along with the queue.
        push_s   = inflight_r && !redirect_valid;
    end

    // Output drive: head entry is presented only while the queue is non-empty.
    always_comb begin
        imem_req    = issue_s;
        imem_addr   = fetch_pc_r;
        instr_valid = valid_s;
        instr       = valid_s ? data_mem_r[head_r] : {INSTR_WIDTH{1'b0}};
        instr_pc    = valid_s ? pc_mem_r[head_r]   : {ADDR_WIDTH{1'b0}};
        queue_count = count_r;
    end

    // PC, in-flight tracking and queue pointers; reset beats redirect beats normal flow.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_WIDTH{1'b0}};
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r    <= redirect_pc;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_WIDTH{1'b0}};
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else begin
            inflight_r    <= issue_s;
            inflight_pc_r <= fetch_pc_r;
            if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + ADDR_WIDTH'(1);
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage: the returning word and its tagged PC land at the tail.
    always_ff @(posedge clock) begin
        if (!reset && push_s) begin
            data_mem_r[tail_r] <= imem_rdata;
            pc_mem_r[tail_r]   <= inflight_pc_r;
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Parametrised fetch front-end for the processor core. It owns the program counter, issues word reads to a synchronous instruction memory with fixed one-cycle latency, and buffers returned words in a prefetch queue. Decode consumes the queue through a valid/ready handshake. Decode or execute can redirect the PC, which flushes all buffered and in-flight fetches.

Parameters:
ADDR_WIDTH, 8, PC / instruction-memory word-address width
INSTR_WIDTH, 16, instruction word width
QUEUE_DEPTH, 4, prefetch queue entries (power of two, >= 2)
RESET_PC, 0, PC value loaded on reset

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  read request to instruction memory this cycle
imem_addr  out  ADDR_WIDTH  word address of the request
imem_rdata  in  INSTR_WIDTH  read data, valid the cycle after imem_req
redirect_valid  in  1  load new PC, flush queue and in-flight fetch
redirect_pc  in  ADDR_WIDTH  target PC for redirect
instr_valid  out  1  queue head holds a valid instruction
instr  out  INSTR_WIDTH  queue-head instruction
instr_pc  out  ADDR_WIDTH  address instr was fetched from
instr_ready  in  1  decode accepts head when instr_valid&&instr_ready
queue_count  out  $clog2(QUEUE_DEPTH+1)  occupied entries

Behaviour:
- Reset (sampled on the edge):
  - fetch_pc=RESET_PC; queue empty; in-flight flag cleared.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, queue_count=0.
- Issue rule: imem_req=1 when not reset, not redirect_valid, and queue_count + inflight − pop_this_cycle < QUEUE_DEPTH.
  - imem_addr=fetch_pc.
  - On issue, fetch_pc increments by 1, wrapping modulo 2^ADDR_WIDTH (max address followed by 0).
- Response: the cycle after an issue, imem_rdata and the tagged PC are written into the queue tail at the clock edge, unless squashed. No response is ever dropped for lack of space; the issue rule guarantees room.
- Pop: a handshake (instr_valid&&instr_ready) removes the head at the edge. Push and pop in the same cycle leave queue_count unchanged.
- Output timing: instr/instr_pc are driven from the queue head and are stable while instr_valid=1 and instr_ready=0.
- Latency:
  - Request at cycle t → entry written end of t+1 → instr_valid visible at t+2.
  - After reset deasserts, the first request is in cycle 0 at RESET_PC; instr_valid=1 in cycle 2.
- Steady state with instr_ready held 1: one instruction per cycle, no bubbles.
- Redirect in cycle R:
  - imem_req=0 in R.
  - Queue flushed at the R edge; the response arriving in R+1 for any pre-redirect request is discarded.
  - fetch_pc=redirect_pc; request at redirect_pc in R+1; instr_valid=1 with instr_pc=redirect_pc in R+3.
  - instr_valid may be 1 in R. A handshake in R counts as accepted; the entry is then flushed with the rest.
  - redirect_valid in consecutive cycles: the last one wins; each restarts the sequence.
- Full queue: queue_count=QUEUE_DEPTH with nothing in flight → imem_req=0 until a pop. A pop in cycle t allows an issue in the same cycle t.
- Reset asserted mid-operation overrides redirect and handshake. All state returns to reset values in the next cycle; in-flight data is discarded.
- Queue pointers are $clog2(QUEUE_DEPTH) bits and wrap naturally.

Test Plan:
- Reset release, instr_ready=1, imem holds mem[i]=16'hA000+i → instr_valid from cycle 2; instr_pc 0,1,2,3… each cycle; instr=16'hA000,16'hA001…
- instr_ready=0 for 10 cycles after reset → queue_count saturates at 4; imem_req=0 once 4 are held or in flight. Raise ready → pcs 0..3 then 4 in consecutive cycles, no gap, no duplicates.
- Redirect to 8'h40 while queue holds 3 entries and 1 in flight → next instr_valid exactly 3 cycles later with instr_pc=8'h40, then 8'h41. Stale pcs never appear.
- RESET_PC=8'hFE, ready=1 → instr_pc sequence FE, FF, 00, 01 (wrap).
- Handshake and redirect (target 8'h10) in the same cycle → handshake counted; subsequent instr_pc starts at 8'h10.
- Reset asserted in the cycle a response returns → next cycle instr_valid=0, queue_count=0, imem_addr=RESET_PC; the first post-reset instruction is from RESET_PC.
